// File: rtl/controlador_elevador_pkg.sv
// Shared types and constants for the elevator movement/door controller.
// Floor masks give the request bits strictly above or below a given floor.
package controlador_elevador_pkg;

    localparam int N_ANDARES = 4;

    localparam logic [1:0] ANDAR_TERREO   = 2'd0;
    localparam logic [1:0] ANDAR_TERCEIRO = 2'd3;

    typedef enum logic [2:0] {
        PARADO       = 3'd0,
        SUBINDO      = 3'd1,
        DESCENDO     = 3'd2,
        LIMPA        = 3'd3,
        PORTA_ABERTA = 3'd4
    } estado_t;

    typedef enum logic {
        DIR_SUBIR  = 1'b0,
        DIR_DESCER = 1'b1
    } dir_t;

    function automatic logic [N_ANDARES-1:0] mascara_acima(input logic [1:0] andar);
        logic [N_ANDARES-1:0] m;
        m = '0;
        for (int i = 0; i < N_ANDARES; i++) begin
            if (i > int'(andar)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [N_ANDARES-1:0] mascara_abaixo(input logic [1:0] andar);
        logic [N_ANDARES-1:0] m;
        m = '0;
        for (int i = 0; i < N_ANDARES; i++) begin
            if (i < int'(andar)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/controlador_elevador_if.sv
// Link between the controller and the floor-request memory.
interface controlador_elevador_if;
    logic [3:0] pedidos;
    logic [1:0] endereco;
    logic       escrita;
    logic       dado;

    modport master (input pedidos, output endereco, output escrita, output dado);
    modport slave  (output pedidos, input endereco, input escrita, input dado);
endinterface

// File: rtl/controlador_elevador_contador_temporizador.sv
// Up-counting timer shared by travel and door phases; terminal flags count == limite.
module contador_temporizador #(
    parameter int W_CONT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              zera,
    input  logic              habilita,
    input  logic [W_CONT-1:0] limite,
    output logic              terminal
);

    logic [W_CONT-1:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (zera) begin
            cont_d = '0;
        end else if (habilita) begin
            cont_d = cont_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign terminal = (cont_q == limite);

endmodule

// File: rtl/controlador_elevador.sv
// Movement/door FSM for a 4-floor elevator, serving requests SCAN-style.
// States: PARADO idle | SUBINDO/DESCENDO travelling | LIMPA clear request | PORTA_ABERTA door open.
module controlador_elevador
    import controlador_elevador_pkg::*;
#(
    parameter int TEMPO_ANDAR = 8,
    parameter int TEMPO_PORTA = 4,
    parameter int W_CONT      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    controlador_elevador_if.master        mem,
    output logic [1:0]                    andar_atual,
    output logic                          subindo,
    output logic                          descendo,
    output logic                          porta_aberta
);

    localparam logic [W_CONT-1:0] LIM_ANDAR = W_CONT'(TEMPO_ANDAR - 1);
    localparam logic [W_CONT-1:0] LIM_PORTA = W_CONT'(TEMPO_PORTA - 1);

    estado_t    estado_q, estado_d;
    logic [1:0] andar_q, andar_d;
    dir_t       dir_q, dir_d;

    logic acima, abaixo, aqui;
    logic fim_tempo, zera_tempo, conta_tempo;
    logic [W_CONT-1:0] limite_tempo;

    assign acima  = |(mem.pedidos & mascara_acima(andar_q));
    assign abaixo = |(mem.pedidos & mascara_abaixo(andar_q));
    assign aqui   = mem.pedidos[andar_q];

    always_comb begin
        estado_d = estado_q;
        andar_d  = andar_q;
        dir_d    = dir_q;
        case (estado_q)
            PARADO: begin
                if (aqui)        estado_d = LIMPA;
                else if (acima)  estado_d = SUBINDO;
                else if (abaixo) estado_d = DESCENDO;
            end
            SUBINDO: begin
                if (fim_tempo) begin
                    if (andar_q != ANDAR_TERCEIRO) begin
                        andar_d = andar_q + 2'd1;
                        dir_d   = DIR_SUBIR;
                    end
                    // Decision is taken on the floor just reached.
                    if (mem.pedidos[andar_d])                          estado_d = LIMPA;
                    else if (|(mem.pedidos & mascara_acima(andar_d)))  estado_d = SUBINDO;
                    else                                               estado_d = PARADO;
                end
            end
            DESCENDO: begin
                if (fim_tempo) begin
                    if (andar_q != ANDAR_TERREO) begin
                        andar_d = andar_q - 2'd1;
                        dir_d   = DIR_DESCER;
                    end
                    if (mem.pedidos[andar_d])                          estado_d = LIMPA;
                    else if (|(mem.pedidos & mascara_abaixo(andar_d))) estado_d = DESCENDO;
                    else                                               estado_d = PARADO;
                end
            end
            LIMPA: begin
                estado_d = PORTA_ABERTA;
            end
            PORTA_ABERTA: begin
                if (aqui) begin
                    estado_d = LIMPA;
                end else if (fim_tempo) begin
                    if (dir_q == DIR_SUBIR && acima)        estado_d = SUBINDO;
                    else if (dir_q == DIR_DESCER && abaixo) estado_d = DESCENDO;
                    else if (acima)                         estado_d = SUBINDO;
                    else if (abaixo)                        estado_d = DESCENDO;
                    else                                    estado_d = PARADO;
                end
            end
            default: begin
                estado_d = PARADO;
            end
        endcase
    end

    // Timer restarts on every state change and on every expiry within a state.
    assign zera_tempo   = (estado_d != estado_q) || fim_tempo;
    assign conta_tempo  = (estado_q == SUBINDO) || (estado_q == DESCENDO) ||
                          (estado_q == PORTA_ABERTA);
    assign limite_tempo = (estado_q == PORTA_ABERTA) ? LIM_PORTA : LIM_ANDAR;

    contador_temporizador #(
        .W_CONT (W_CONT)
    ) u_temporizador (
        .clk      (clk),
        .reset_n  (reset_n),
        .zera     (zera_tempo),
        .habilita (conta_tempo),
        .limite   (limite_tempo),
        .terminal (fim_tempo)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q <= PARADO;
            andar_q  <= ANDAR_TERREO;
            dir_q    <= DIR_SUBIR;
        end else begin
            estado_q <= estado_d;
            andar_q  <= andar_d;
            dir_q    <= dir_d;
        end
    end

    assign mem.endereco = andar_q;
    assign mem.escrita  = (estado_q == LIMPA);
    assign mem.dado     = 1'b0;

    assign andar_atual  = andar_q;
    assign subindo      = (estado_q == SUBINDO);
    assign descendo     = (estado_q == DESCENDO);
    assign porta_aberta = (estado_q == LIMPA) || (estado_q == PORTA_ABERTA);

endmodule

// File: tb/tb_controlador_elevador.sv
// Scoreboard bench: each scenario queues the expected write strobes (floor, cycle);
// a monitor pops one entry per observed escrita. Memory clears a bit on each strobe.
module tb_controlador_elevador;

    typedef struct {
        logic [1:0] andar;
        int         ciclo;
    } esperado_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] pedidos;
    int         ciclo = 0;
    int         n_testes = 0;
    int         n_falhas = 0;

    esperado_t  fila[$];
    esperado_t  e_mon;

    logic [1:0] andar_atual;
    logic       subindo, descendo, porta_aberta;

    controlador_elevador_if bus();
    assign bus.pedidos = pedidos;

    controlador_elevador #(
        .TEMPO_ANDAR (8),
        .TEMPO_PORTA (4),
        .W_CONT      (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem          (bus),
        .andar_atual  (andar_atual),
        .subindo      (subindo),
        .descendo     (descendo),
        .porta_aberta (porta_aberta)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    // Request memory: the controller's write strobe clears the addressed bit.
    always @(posedge clk) begin
        if (bus.escrita === 1'b1) pedidos[bus.endereco] = bus.dado;
    end

    task automatic checa(input string nome, input int obtido, input int esperado);
        n_testes++;
        if (obtido != esperado) begin
            n_falhas++;
            $display("FAIL %s: obtido=%0d esperado=%0d (ciclo %0d)", nome, obtido, esperado, ciclo);
        end
    endtask

    function automatic void espera(input logic [1:0] andar, input int c);
        esperado_t e;
        e.andar = andar;
        e.ciclo = c;
        fila.push_back(e);
    endfunction

    task automatic janela(input int n, output int ns, output int nd, output int np);
        ns = 0;
        nd = 0;
        np = 0;
        repeat (n) begin
            @(negedge clk);
            ns += int'(subindo);
            nd += int'(descendo);
            np += int'(porta_aberta);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (bus.escrita === 1'b1) begin
            if (fila.size() == 0) begin
                n_testes++;
                n_falhas++;
                $display("FAIL escrita_inesperada: andar=%0d ciclo=%0d esperado=nenhuma",
                         bus.endereco, ciclo);
            end else begin
                e_mon = fila.pop_front();
                checa("escrita_andar", int'(bus.endereco), int'(e_mon.andar));
                checa("escrita_ciclo", ciclo, e_mon.ciclo);
                checa("escrita_dado", int'(bus.dado), 0);
            end
        end
    end

    initial begin
        int c, ns, nd, np, ns2, nd2, np2;

        reset_n = 1'b0;
        pedidos = 4'b0000;
        repeat (3) @(negedge clk);
        checa("reset_andar", int'(andar_atual), 0);
        checa("reset_subindo", int'(subindo), 0);
        checa("reset_descendo", int'(descendo), 0);
        checa("reset_porta", int'(porta_aberta), 0);
        checa("reset_escrita", int'(bus.escrita), 0);
        checa("reset_endereco", int'(bus.endereco), 0);
        reset_n = 1'b1;

        janela(20, ns, nd, np);
        checa("ocioso_mov", ns + nd, 0);
        checa("ocioso_porta", np, 0);
        checa("ocioso_andar", int'(andar_atual), 0);

        // 0 -> 2
        c = ciclo;
        pedidos = 4'b0100;
        espera(2'd2, c + 17);
        janela(30, ns, nd, np);
        checa("a_subindo", ns, 16);
        checa("a_descendo", nd, 0);
        checa("a_porta", np, 5);
        checa("a_andar", int'(andar_atual), 2);

        // At 2 after going up: serve 2, then 3 ahead, then descend to 0
        c = ciclo;
        pedidos = 4'b1101;
        espera(2'd2, c + 1);
        espera(2'd3, c + 14);
        espera(2'd0, c + 43);
        janela(50, ns, nd, np);
        checa("b_subindo", ns, 8);
        checa("b_descendo", nd, 24);
        checa("b_porta", np, 15);
        checa("b_andar", int'(andar_atual), 0);

        // Button re-pressed while the door is open
        c = ciclo;
        pedidos = 4'b0001;
        espera(2'd0, c + 1);
        janela(2, ns, nd, np);
        checa("c_porta_antes", np, 2);
        pedidos[0] = 1'b1;
        espera(2'd0, c + 3);
        janela(10, ns2, nd2, np2);
        checa("c_porta_reinicio", np2, 5);
        checa("c_mov", ns + nd + ns2 + nd2, 0);

        // 0 -> 3
        c = ciclo;
        pedidos = 4'b1000;
        espera(2'd3, c + 25);
        janela(32, ns, nd, np);
        checa("e_subindo", ns, 24);
        checa("e_porta", np, 5);
        checa("e_andar", int'(andar_atual), 3);

        // Request at top floor while idle there: no movement
        c = ciclo;
        pedidos = 4'b1000;
        espera(2'd3, c + 1);
        janela(8, ns, nd, np);
        checa("t_mov", ns + nd, 0);
        checa("t_porta", np, 5);
        checa("t_andar", int'(andar_atual), 3);

        // Descending stop at 2 with requests both sides: keep going down first
        c = ciclo;
        pedidos = 4'b0100;
        espera(2'd2, c + 9);
        janela(9, ns, nd, np);
        checa("f_descendo1", nd, 8);
        checa("f_porta1", np, 1);
        pedidos = pedidos | 4'b1001;
        espera(2'd0, c + 30);
        espera(2'd3, c + 59);
        janela(62, ns2, nd2, np2);
        checa("f_descendo2", nd2, 16);
        checa("f_subindo2", ns2, 24);
        checa("f_porta2", np2, 14);
        checa("f_andar", int'(andar_atual), 3);

        // Reset from floor 3, then reset mid-travel at timer=5 of the second leg
        reset_n = 1'b0;
        pedidos = 4'b0000;
        repeat (2) @(negedge clk);
        checa("d_reset_andar", int'(andar_atual), 0);
        checa("d_reset_porta", int'(porta_aberta), 0);
        reset_n = 1'b1;
        pedidos = 4'b1000;
        janela(13, ns, nd, np);
        @(negedge clk);
        checa("d_subindo_antes", int'(subindo), 1);
        checa("d_andar_antes", int'(andar_atual), 1);
        reset_n = 1'b0;
        pedidos = 4'b0000;
        @(negedge clk);
        checa("d_subindo_reset", int'(subindo), 0);
        checa("d_andar_reset", int'(andar_atual), 0);
        checa("d_descendo_reset", int'(descendo), 0);
        checa("d_porta_reset", int'(porta_aberta), 0);
        reset_n = 1'b1;
        janela(20, ns, nd, np);
        checa("d_ocioso", ns + nd + np, 0);
        checa("d_andar_final", int'(andar_atual), 0);

        checa("fila_vazia", fila.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
